// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Shares the data-memory read/write ports between the core
//            (always zero-latency, never stalled) and a host/loader port that
//            only issues in cycles where the core leaves the needed port idle.
//            Optional starvation guard: define DMEM_ARB_STARVE_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
    parameter int ADDR_WID     = 16,
    parameter int DATA_WID     = 8,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_rd_en,
    input  logic [ADDR_WID-1:0] core_rd_addr,
    input  logic                core_wr_en,
    input  logic [ADDR_WID-1:0] core_wr_addr,
    input  logic [DATA_WID-1:0] core_wr_data,
    output logic                core_hold,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [ADDR_WID-1:0] host_addr,
    input  logic [DATA_WID-1:0] host_wdata,
    output logic                host_busy,
    output logic                host_ack,
    output logic [DATA_WID-1:0] host_rdata,
    output logic [ADDR_WID-1:0] mem_rd_addr,
    output logic [ADDR_WID-1:0] mem_wr_addr,
    output logic [DATA_WID-1:0] mem_wr_data,
    output logic                mem_wr_en,
    input  logic [DATA_WID-1:0] mem_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_RDATA = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam logic [7:0] c_starve_limit = 8'(STARVE_LIMIT);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_req_we;
    logic [ADDR_WID-1:0]   r_req_addr;
    logic [DATA_WID-1:0]   r_req_wdata;
    logic [7:0]            r_wait_cnt;
    logic [DATA_WID-1:0]   r_rdata;
    logic                  w_port_free;
    logic                  w_force;
    logic                  w_issue;
    logic                  w_host_rd_issue;
    logic                  w_host_wr_issue;

    // A read only needs the read port, a write only the write port.
    assign w_port_free     = r_req_we ? ~core_wr_en : ~core_rd_en;
    assign w_issue         = (r_state == S_WAIT) && (w_port_free || w_force);
    assign w_host_rd_issue = w_issue && !r_req_we;
    assign w_host_wr_issue = w_issue &&  r_req_we;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (host_req) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_issue)  w_state_nxt = r_req_we ? S_ACK : S_RDATA;
            S_RDATA: w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_wait_cnt  <= 8'd0;
            r_rdata     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && host_req) begin
                r_req_we    <= host_we;
                r_req_addr  <= host_addr;
                r_req_wdata <= host_wdata;
                r_wait_cnt  <= 8'd0;
            end
            if (r_state == S_WAIT) begin
                if (w_issue)
                    r_wait_cnt <= 8'd0;
                else if (r_wait_cnt != 8'hFF)
                    r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            // Memory returns data the cycle after issue; this is that cycle.
            if (r_state == S_RDATA)
                r_rdata <= mem_dout;
        end
    end

`ifdef DMEM_ARB_STARVE_EN
    logic r_hold;

    always_ff @(posedge clk) begin
        if (reset)
            r_hold <= 1'b0;
        else
            r_hold <= (r_state == S_WAIT) && !w_issue && (r_wait_cnt == c_starve_limit);
    end

    // During hold the host owns the contended port regardless of core enables.
    assign w_force   = r_hold;
    assign core_hold = r_hold;
`else
    assign w_force   = 1'b0;
    assign core_hold = 1'b0;
`endif

    assign host_busy   = (r_state != S_IDLE);
    assign host_ack    = (r_state == S_ACK);
    assign host_rdata  = r_rdata;

    assign mem_rd_addr = w_host_rd_issue ? r_req_addr  : core_rd_addr;
    assign mem_wr_en   = core_wr_en | w_host_wr_issue;
    assign mem_wr_addr = w_host_wr_issue ? r_req_addr  : core_wr_addr;
    assign mem_wr_data = w_host_wr_issue ? r_req_wdata : core_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Purpose  : Directed self-checking bench for dmem_port_arbiter with a small
//            registered-read memory model behind the mem_* ports.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    localparam int c_aw = 16;
    localparam int c_dw = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            core_rd_en;
    logic [c_aw-1:0] core_rd_addr;
    logic            core_wr_en;
    logic [c_aw-1:0] core_wr_addr;
    logic [c_dw-1:0] core_wr_data;
    logic            core_hold;
    logic            host_req;
    logic            host_we;
    logic [c_aw-1:0] host_addr;
    logic [c_dw-1:0] host_wdata;
    logic            host_busy;
    logic            host_ack;
    logic [c_dw-1:0] host_rdata;
    logic [c_aw-1:0] mem_rd_addr;
    logic [c_aw-1:0] mem_wr_addr;
    logic [c_dw-1:0] mem_wr_data;
    logic            mem_wr_en;
    logic [c_dw-1:0] mem_dout;

    logic [c_dw-1:0] mem_model [0:255];

    int n_checks = 0;
    int n_pass   = 0;

    dmem_port_arbiter #(
        .ADDR_WID     (c_aw),
        .DATA_WID     (c_dw),
        .STARVE_LIMIT (3)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .core_rd_en   (core_rd_en),
        .core_rd_addr (core_rd_addr),
        .core_wr_en   (core_wr_en),
        .core_wr_addr (core_wr_addr),
        .core_wr_data (core_wr_data),
        .core_hold    (core_hold),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_busy    (host_busy),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .mem_rd_addr  (mem_rd_addr),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .mem_dout     (mem_dout)
    );

    always #5 clk = ~clk;

    // Registered read, read-before-write on the same address.
    always @(posedge clk) begin
        mem_dout <= mem_model[mem_rd_addr[7:0]];
        if (mem_wr_en)
            mem_model[mem_wr_addr[7:0]] <= mem_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        int acks;
        int bad;
        bit seen;

        reset = 1'b1; core_rd_en = 1'b0; core_rd_addr = '0; core_wr_en = 1'b0;
        core_wr_addr = '0; core_wr_data = '0; host_req = 1'b0; host_we = 1'b0;
        host_addr = '0; host_wdata = '0;

        // Reset state
        nxt();
        nxt(); core_wr_en = 1'b1; #1;
        check("rst_busy",  32'(host_busy),  0);
        check("rst_ack",   32'(host_ack),   0);
        check("rst_rdata", 32'(host_rdata), 0);
        check("rst_hold",  32'(core_hold),  0);
        check("rst_wr_en", 32'(mem_wr_en),  1);
        nxt(); core_wr_en = 1'b0; reset = 1'b0;

        // Uncontended host write then read of the same address
        nxt(); host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 8'h5A; #1;
        check("w_idle_busy", 32'(host_busy), 0);
        nxt(); host_req = 1'b0; #1;
        check("w_issue_busy", 32'(host_busy),   1);
        check("w_issue_en",   32'(mem_wr_en),   1);
        check("w_issue_addr", 32'(mem_wr_addr), 'h0010);
        check("w_issue_data", 32'(mem_wr_data), 'h5A);
        check("w_issue_ack",  32'(host_ack),    0);
        nxt(); #1;
        check("w_ack", 32'(host_ack), 1);
        nxt(); host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010; #1;
        nxt(); host_req = 1'b0; #1;
        check("r_issue_addr", 32'(mem_rd_addr), 'h0010);
        nxt(); #1;
        check("r_rdata_ack", 32'(host_ack), 0);
        nxt(); #1;
        check("r_ack",   32'(host_ack),   1);
        check("r_rdata", 32'(host_rdata), 'h5A);

        // Host read alongside continuous core stores
        nxt(); core_wr_en = 1'b1; core_wr_addr = 16'h0010; core_wr_data = 8'h33;
        nxt(); core_wr_addr = 16'h0040; core_wr_data = 8'h01;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010; #1;
        check("ind_core_addr", 32'(mem_wr_addr), 'h0040);
        nxt(); host_req = 1'b0; core_wr_data = 8'h02; #1;
        check("ind_rd_addr", 32'(mem_rd_addr), 'h0010);
        check("ind_wr_en",   32'(mem_wr_en),   1);
        check("ind_wr_addr", 32'(mem_wr_addr), 'h0040);
        check("ind_wr_data", 32'(mem_wr_data), 'h02);
        nxt(); core_wr_data = 8'h03; #1;
        check("ind_ack_early", 32'(host_ack), 0);
        nxt(); core_wr_data = 8'h04; #1;
        check("ind_ack",   32'(host_ack),   1);
        check("ind_rdata", 32'(host_rdata), 'h33);
        nxt(); core_wr_en = 1'b0; core_rd_en = 1'b1; core_rd_addr = 16'h0040;
        nxt(); core_rd_en = 1'b0; #1;
        check("ind_core_store", 32'(mem_dout), 'h04);

        // Read contention: core holds the read port for six cycles
        nxt(); host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010; #1;
        for (int i = 1; i <= 6; i++) begin
            nxt(); host_req = 1'b0; core_rd_en = 1'b1; core_rd_addr = 16'(16'h0100 + i); #1;
            check("cont_pass", 32'(mem_rd_addr), 32'(16'h0100 + i));
            check("cont_busy", 32'(host_busy), 1);
        end
        nxt(); core_rd_en = 1'b0; core_rd_addr = 16'h0200; #1;
        check("cont_issue", 32'(mem_rd_addr), 'h0010);
        nxt(); #1;
        check("cont_ack_early", 32'(host_ack), 0);
        nxt(); #1;
        check("cont_ack",   32'(host_ack),   1);
        check("cont_rdata", 32'(host_rdata), 'h33);

        // Request while busy is ignored; next IDLE request is accepted
        nxt(); host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0030; host_wdata = 8'h77;
        nxt(); host_req = 1'b0; core_wr_en = 1'b1; core_wr_addr = 16'h0050; core_wr_data = 8'h11;
        nxt(); host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0060; #1;
        check("ign_busy", 32'(host_busy), 1);
        nxt(); host_req = 1'b0;
        nxt(); core_wr_en = 1'b0; #1;
        check("ign_wr_en",   32'(mem_wr_en),   1);
        check("ign_wr_addr", 32'(mem_wr_addr), 'h0030);
        check("ign_wr_data", 32'(mem_wr_data), 'h77);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            nxt(); #1;
            if (host_ack) acks++;
        end
        check("ign_one_ack", 32'(acks), 1);
        nxt(); host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0030; #1;
        check("ign_idle_busy", 32'(host_busy), 0);
        nxt(); host_req = 1'b0; #1;
        check("acc_busy", 32'(host_busy), 1);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            nxt(); #1;
            if (host_ack) seen = 1'b1;
        end
        check("acc_ack",   32'(seen),       1);
        check("acc_rdata", 32'(host_rdata), 'h77);

        // Starvation: core stores every cycle
        nxt(); core_wr_en = 1'b1; core_wr_addr = 16'h0050; core_wr_data = 8'h00;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0020; host_wdata = 8'hA5;
`ifdef DMEM_ARB_STARVE_EN
        bad = 0;
        for (int i = 1; i <= 4; i++) begin
            nxt(); host_req = 1'b0; #1;
            if (core_hold || mem_wr_addr != 16'h0050) bad++;
        end
        check("stv_no_early_hold", 32'(bad), 0);
        nxt(); #1;
        check("stv_hold",    32'(core_hold),   1);
        check("stv_wr_addr", 32'(mem_wr_addr), 'h0020);
        check("stv_wr_data", 32'(mem_wr_data), 'hA5);
        nxt(); #1;
        check("stv_ack",      32'(host_ack),  1);
        check("stv_hold_end", 32'(core_hold), 0);
        nxt(); core_wr_en = 1'b0;
`else
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            nxt(); host_req = 1'b0; #1;
            if (host_ack || core_hold) bad++;
        end
        check("stv_off_no_ack_hold", 32'(bad), 0);
        check("stv_off_busy", 32'(host_busy), 1);
        nxt(); reset = 1'b1;
        nxt(); reset = 1'b0; core_wr_en = 1'b0; #1;
        check("stv_off_rst_busy", 32'(host_busy), 0);
`endif

        // Reset in RDATA aborts the read
        nxt(); host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
        nxt(); host_req = 1'b0;
        nxt(); reset = 1'b1; #1;
        check("ab_rdata_busy", 32'(host_busy), 1);
        nxt(); reset = 1'b0; #1;
        check("ab_busy",  32'(host_busy),  0);
        check("ab_ack",   32'(host_ack),   0);
        check("ab_rdata", 32'(host_rdata), 0);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            nxt(); #1;
            if (host_ack) acks++;
        end
        check("ab_no_ack", 32'(acks), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single-ported-per-direction data memory (one read port, one write port, registered read data) between the pipeline's MEM/WB stage and a host/loader port. The core always has zero-latency, zero-stall access to each port. A host transaction is issued only in a cycle where the core leaves the required port idle. An optional starvation guard forces a host slot by asking the core to hold.

## Interface
Parameters:
- ADDR_WID, 16, data memory address width
- DATA_WID, 8, data memory word width
- STARVE_LIMIT, 15, blocked WAIT cycles before a forced host slot (1..255)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- core_rd_en  in  1  core uses the read port this cycle
- core_rd_addr  in  ADDR_WID  core read address
- core_wr_en  in  1  core store this cycle
- core_wr_addr  in  ADDR_WID  core write address
- core_wr_data  in  DATA_WID  core store data
- core_hold  out  1  request the core suppress its memory access this cycle (macro only)
- host_req  in  1  host transaction request, sampled only when host_busy=0
- host_we  in  1  1=write, 0=read, sampled with host_req
- host_addr  in  ADDR_WID  host address, sampled with host_req
- host_wdata  in  DATA_WID  host write data, sampled with host_req
- host_busy  out  1  transaction in flight (state != IDLE)
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  DATA_WID  read result, valid while host_ack=1, held until next read completes
- mem_rd_addr  out  ADDR_WID  to data memory read address
- mem_wr_addr  out  ADDR_WID  to data memory write address
- mem_wr_data  out  DATA_WID  to data memory write data
- mem_wr_en  out  1  to data memory store enable
- mem_dout  in  DATA_WID  data memory read data, one cycle after address

## Operation
- FSM states: IDLE, WAIT, RDATA, ACK.
- IDLE: host_req=1 latches host_we/addr/wdata into request registers, clears wait_cnt, goes to WAIT. host_req while busy is ignored.
- WAIT: the host port is free when the required port is idle: read needs core_rd_en=0, write needs core_wr_en=0. Read and write ports are independent, so a host read may coincide with a core write and vice versa.
  - Port free: issue this cycle (the issue cycle, I) by muxing the latched request onto the mem_* outputs. A write goes to ACK; a read goes to RDATA.
  - Port not free: remain in WAIT and increment wait_cnt, saturating at 255.
- RDATA: capture mem_dout into host_rdata, go to ACK.
- ACK: host_ack=1 for exactly one cycle, go to IDLE. A new host_req is accepted in the following IDLE cycle, not in ACK.
- Mem muxing is combinational and selects the core unless a host issue happens this cycle:
  - mem_rd_addr = host issue read ? latched addr : core_rd_addr.
  - mem_wr_en = core_wr_en | host write issue.
  - mem_wr_addr and mem_wr_data select the host only on a host write issue.
- Core address/data are passed through when the core enable is low (don't-care to memory).
- Reset values:
  - state=IDLE, wait_cnt=0, host_busy=0, host_ack=0, host_rdata=0, core_hold=0, request registers=0.
  - mem_wr_en = core_wr_en, because the output is combinational.
- Reset mid-transaction aborts it with no ack. A host write not yet issued is never written.

## Timing
- Core path: 0 added cycles and purely combinational. The core's read data arrives on mem_dout at the next cycle, unchanged.
- Host write: req at T, issue no earlier than T+1, ack at I+1. Uncontended minimum is ack at T+2.
- Host read: req at T, issue at I ≥ T+1, capture at I+1, ack and rdata at I+2. Uncontended minimum is ack at T+3.
- When the core and host target the same address on the same cycle with the write port free (host write, core read), the core reads the old data. The memory's own read-before-write order applies.

## Configuration
- DMEM_ARB_STARVE_EN defined:
  - When in WAIT with wait_cnt == STARVE_LIMIT, core_hold is asserted (registered) for the next cycle.
  - In that cycle the host issues unconditionally, overriding the core on the contended port.
  - Any core access on that port during core_hold is dropped. Suppressing it is the core's responsibility.
  - wait_cnt clears on issue.
- DMEM_ARB_STARVE_EN undefined: core_hold is tied 0 and the host may wait indefinitely.

## Test plan
- Idle core, host write 0x5A to 0x0010 at T: ack at T+2 with mem_wr_en/addr/data driven by the host at T+1. A following host read of 0x0010 acks at T+3 with rdata=0x5A.
- Independent ports: core_wr_en held high, host read of 0x0010 (preloaded 0x33) → issues at T+1, ack at T+3, rdata=0x33; no core store is lost.
- Contention: core_rd_en high for 6 cycles after a host read request at T → host_busy stays high, issue at T+7, ack at T+9; core read addresses pass through every cycle.
- Busy ignore: second host_req during WAIT → ignored, exactly one ack; req in the IDLE cycle after ack → accepted.
- Starvation (macro on, STARVE_LIMIT=3): core_wr_en high permanently, host write 0xA5 to 0x0020 → core_hold pulses one cycle after wait_cnt reaches 3, and the host write issues that cycle. Macro off: no ack ever and core_hold=0.
- Reset asserted in RDATA → next cycle state IDLE, host_ack=0, host_rdata=0, no ack afterwards.
